bist_march_ctrl: RTL

March C- sequencer for the on-chip test RAM behind the JTAG RUNBIST instruction. Once RUNBIST is selected, it generates the complete address, write-enable and data stream for a DEPTH-word RAM and compares the read data on the fly. It reports completion on `stop`, a sticky `err` flag and the first failing element/address on `BIST_LOG`. It sits between the TAP instruction decode and the RAM under test, and clocks on the system `clk`.

---
 rtl/bist_march_ctrl_pkg.sv | 62 ++++++
 rtl/bist_march_ctrl_if.sv | 14 +
 rtl/bist_march_ctrl_addr_gen.sv | 29 ++
 rtl/bist_march_ctrl.sv | 150 +++++++++++++++
 4 files changed

// File: rtl/bist_march_ctrl_pkg.sv
// Shared types and March C- element table for the RUNBIST sequencer.
package bist_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WR,
    S_RD,
    S_CMP,
    S_DONE
  } bist_state_e;

  localparam int NUM_ELEM = 6;
  localparam int ELEM_W   = 3;
  localparam logic [ELEM_W-1:0] LAST_ELEM = ELEM_W'(NUM_ELEM - 1);

  // Element table, bit e describes element e. Tables are padded to 2**ELEM_W
  // entries so a look-ahead past the last element reads a harmless 0.
  //   0: up   w0        3: down r0,w1
  //   1: up   r0,w1     4: down r1,w0
  //   2: up   r1,w0     5: up   r0
  localparam logic [7:0] EL_DOWN   = 8'b0001_1000;
  localparam logic [7:0] EL_RD_ONE = 8'b0001_0100;
  localparam logic [7:0] EL_WR_ONE = 8'b0000_1010;
  localparam logic [7:0] EL_HAS_RD = 8'b0011_1110;
  localparam logic [7:0] EL_HAS_WR = 8'b0001_1111;

  // BIST_LOG layout: {element[2:0], address[4:0]}
  localparam int LOG_ADDR_LSB = 0;
  localparam int LOG_ADDR_W   = 5;
  localparam int LOG_ELEM_LSB = 5;
  localparam int LOG_ELEM_W   = 3;

  function automatic logic el_down(input logic [ELEM_W-1:0] e);
    return EL_DOWN[e];
  endfunction

  function automatic logic el_rd_one(input logic [ELEM_W-1:0] e);
    return EL_RD_ONE[e];
  endfunction

  function automatic logic el_wr_one(input logic [ELEM_W-1:0] e);
    return EL_WR_ONE[e];
  endfunction

  function automatic logic el_has_rd(input logic [ELEM_W-1:0] e);
    return EL_HAS_RD[e];
  endfunction

  function automatic logic el_has_wr(input logic [ELEM_W-1:0] e);
    return EL_HAS_WR[e];
  endfunction

  function automatic logic [7:0] mk_log(input logic [LOG_ELEM_W-1:0] e,
                                        input logic [LOG_ADDR_W-1:0] a);
    logic [7:0] l;
    l = '0;
    l[LOG_ELEM_LSB +: LOG_ELEM_W] = e;
    l[LOG_ADDR_LSB +: LOG_ADDR_W] = a;
    return l;
  endfunction

endpackage

// File: rtl/bist_march_ctrl_if.sv
// RAM-under-test port: the sequencer drives address/strobes/data, RAM returns rdata.
interface bist_march_ctrl_if #(
  parameter int WIDTH  = 3,
  parameter int DATA_W = 4
);
  logic [WIDTH-1:0]  ram_addr;
  logic              ram_we;
  logic              ram_re;
  logic [DATA_W-1:0] ram_wdata;
  logic [DATA_W-1:0] ram_rdata;

  modport master (output ram_addr, ram_we, ram_re, ram_wdata, input ram_rdata);
  modport slave  (input ram_addr, ram_we, ram_re, ram_wdata, output ram_rdata);
endinterface

// File: rtl/bist_march_ctrl_addr_gen.sv
// Up/down address counter bounded to 0..DEPTH-1 with an end-of-sweep flag.
module bist_addr_gen #(
  parameter int DEPTH = 6,
  parameter int WIDTH = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,       // restart sweep
  input  logic             load_down,  // direction of the sweep being loaded
  input  logic             adv,        // step to next address
  input  logic             down,       // direction of the current sweep
  output logic [WIDTH-1:0] addr,
  output logic             last
);

  localparam logic [WIDTH-1:0] TOP = WIDTH'(DEPTH - 1);

  // last is relative to the current sweep direction, so non-power-of-2
  // depths never reach an address above DEPTH-1
  assign last = down ? (addr == '0) : (addr == TOP);

  // address register: load wins over advance
  always_ff @(posedge clk or posedge rst) begin
    if (rst)       addr <= '0;
    else if (load) addr <= load_down ? TOP : '0;
    else if (adv)  addr <= down ? addr - WIDTH'(1) : addr + WIDTH'(1);
  end

endmodule

// File: rtl/bist_march_ctrl.sv
// March C- sequencer: walks six elements over the RAM, compares read data
// in the cycle after each read, keeps a sticky error and first-fail log.
module bist_march_ctrl
  import bist_pkg::*;
#(
  parameter int DEPTH  = 6,
  parameter int DATA_W = 4,
  parameter int WIDTH  = $clog2(DEPTH)
) (
  input  logic                clk,
  input  logic                TLR,
  input  logic                RUNBIST_SELECT,
  bist_march_ctrl_if.master   bus,
  output logic                busy,
  output logic                stop,
  output logic                err,
  output logic [7:0]          BIST_LOG
);

  bist_state_e       state;
  bist_state_e       nxt_first;
  logic [ELEM_W-1:0] elem;
  logic [ELEM_W-1:0] nxt_elem;
  logic [WIDTH-1:0]  addr_q;
  logic              last;
  logic              ag_load;
  logic              ag_load_down;
  logic              ag_adv;
  logic              ag_down;
  logic [DATA_W-1:0] exp_rd;
  logic              miscmp;

  bist_addr_gen #(.DEPTH(DEPTH), .WIDTH(WIDTH)) u_addr (
    .clk       (clk),
    .rst       (TLR),
    .load      (ag_load),
    .load_down (ag_load_down),
    .adv       (ag_adv),
    .down      (ag_down),
    .addr      (addr_q),
    .last      (last)
  );

  // the counter register is itself the registered RAM address
  assign bus.ram_addr = addr_q;

  // address-counter control and compare decode from the current state
  always_comb begin
    nxt_elem     = elem + ELEM_W'(1);
    nxt_first    = el_has_rd(nxt_elem) ? S_RD : S_WR;
    exp_rd       = {DATA_W{el_rd_one(elem)}};
    miscmp       = (bus.ram_rdata != exp_rd);
    ag_down      = el_down(elem);
    ag_load      = 1'b0;
    ag_load_down = 1'b0;
    ag_adv       = 1'b0;
    case (state)
      S_IDLE: begin
        ag_load      = RUNBIST_SELECT;
        ag_load_down = el_down('0);
      end
      S_RD: ag_load = !RUNBIST_SELECT;
      S_WR, S_CMP: begin
        if (!RUNBIST_SELECT) begin
          ag_load = 1'b1;
        end else if (last) begin
          ag_load      = (elem != LAST_ELEM);
          ag_load_down = el_down(nxt_elem);
        end else begin
          ag_adv = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // main FSM; strobes and status are set for the state being entered
  always_ff @(posedge clk or posedge TLR) begin
    if (TLR) begin
      state         <= S_IDLE;
      elem          <= '0;
      bus.ram_we    <= 1'b0;
      bus.ram_re    <= 1'b0;
      bus.ram_wdata <= '0;
      busy          <= 1'b0;
      stop          <= 1'b0;
      err           <= 1'b0;
      BIST_LOG      <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (RUNBIST_SELECT) begin
            state         <= S_WR;
            elem          <= '0;
            bus.ram_we    <= 1'b1;
            bus.ram_wdata <= {DATA_W{el_wr_one('0)}};
            busy          <= 1'b1;
            err           <= 1'b0;
            BIST_LOG      <= '0;
          end
        end
        S_WR, S_RD, S_CMP: begin
          // compare happens even in an aborting cycle; only the log is first-fail
          if (state == S_CMP && miscmp) begin
            err <= 1'b1;
            if (!err) BIST_LOG <= mk_log(elem, LOG_ADDR_W'(addr_q));
          end
          if (!RUNBIST_SELECT) begin
            state      <= S_IDLE;
            bus.ram_we <= 1'b0;
            bus.ram_re <= 1'b0;
            busy       <= 1'b0;
          end else if (state == S_RD) begin
            state         <= S_CMP;
            bus.ram_re    <= 1'b0;
            bus.ram_we    <= el_has_wr(elem);
            bus.ram_wdata <= {DATA_W{el_wr_one(elem)}};
          end else if (!last) begin
            // write-only elements stay in WR; read elements go back to RD
            if (state == S_CMP) begin
              state      <= S_RD;
              bus.ram_we <= 1'b0;
              bus.ram_re <= 1'b1;
            end
          end else if (elem == LAST_ELEM) begin
            state      <= S_DONE;
            bus.ram_we <= 1'b0;
            bus.ram_re <= 1'b0;
            busy       <= 1'b0;
            stop       <= 1'b1;
          end else begin
            elem          <= nxt_elem;
            state         <= nxt_first;
            bus.ram_re    <= (nxt_first == S_RD);
            bus.ram_we    <= (nxt_first == S_WR);
            bus.ram_wdata <= {DATA_W{el_wr_one(nxt_elem)}};
          end
        end
        S_DONE: begin
          if (!RUNBIST_SELECT) begin
            state <= S_IDLE;
            stop  <= 1'b0;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
